// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared stall-cause encodings and register constants for the
//                load-use / stall controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  // Default register address width (32 architectural registers)
  localparam int DEF_ADDR_W = 5;

  // Architectural zero register; writes to it never create a dependency
  localparam int REG_ZERO = 0;

  // Reason the pipeline is not advancing normally this cycle
  typedef enum logic [1:0] {
    CAUSE_NONE  = 2'd0,
    CAUSE_LDU   = 2'd1,
    CAUSE_MEM   = 2'd2,
    CAUSE_FLUSH = 2'd3
  } cause_e;

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard
//  Description : Tracks loads that have left EX but whose data is not yet
//                forwardable. Stage 0 is the load currently in EX; stages
//                1..LOAD_LAT-1 are registered and freeze while hold is set.
//                Raises hit when the instruction in ID reads a pending rd.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int LOAD_LAT = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic              rs1_use,
  input  logic              rs2_use,
  input  logic [ADDR_W-1:0] ex_rd_addr,
  input  logic              ex_mem_read,
  input  logic              hold,
  output logic              hit
);

  // True when a pending destination is actually read by the ID instruction
  function automatic logic src_match(input logic [ADDR_W-1:0] rd);
    return ((rd == rs1_addr) && rs1_use) || ((rd == rs2_addr) && rs2_use);
  endfunction

  logic stage0_v;
  logic stage0_hit;

  // Loads to x0 are never tracked, so x0 can never produce a hit
  assign stage0_v   = ex_mem_read && (ex_rd_addr != ADDR_W'(REG_ZERO));
  assign stage0_hit = stage0_v && src_match(ex_rd_addr);

  generate
    if (LOAD_LAT > 1) begin : g_stages
      localparam int NSTG = LOAD_LAT - 1;

      logic [NSTG:1]     sb_v;
      logic [ADDR_W-1:0] sb_rd [1:NSTG];
      logic [NSTG:1]     stg_hit;

      // Shift pending loads one stage per cycle; freeze during cache stalls
      always_ff @(posedge clk_i) begin
        if (!rst_i) begin
          sb_v <= '0;
          for (int k = 1; k <= NSTG; k++) sb_rd[k] <= '0;
        end else if (!hold) begin
          sb_v[1]  <= stage0_v;
          sb_rd[1] <= ex_rd_addr;
          for (int k = 2; k <= NSTG; k++) begin
            sb_v[k]  <= sb_v[k-1];
            sb_rd[k] <= sb_rd[k-1];
          end
        end
      end

      // Per-stage dependency match against the ID source registers
      always_comb begin
        stg_hit = '0;
        for (int k = 1; k <= NSTG; k++) stg_hit[k] = sb_v[k] && src_match(sb_rd[k]);
      end

      assign hit = stage0_hit || (|stg_hit);
    end else begin : g_no_stages
      // Single-bubble configuration: only the load in EX matters
      logic unused_ctrl;
      assign unused_ctrl = ^{clk_i, rst_i, hold};
      assign hit = stage0_hit;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_stall_ctrl
//  Description : Pipeline stall controller. Arbitrates data-cache stalls,
//                branch flushes and multi-cycle load-use hazards, and drives
//                PC / IF-ID / ID-EX write enables and the bubble mux.
//                Optional macro HAZARD_PERF_CNT_EN adds saturating
//                load-use and mem-stall cycle counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int LOAD_LAT = 2
`ifdef HAZARD_PERF_CNT_EN
  ,
  parameter int CNT_W    = 32
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] IF_ID_RS1addr_i,
  input  logic [ADDR_W-1:0] IF_ID_RS2addr_i,
  input  logic              IF_ID_RS1use_i,
  input  logic              IF_ID_RS2use_i,
  input  logic [ADDR_W-1:0] ID_EX_RDaddr_i,
  input  logic              ID_EX_MemRead_i,
  input  logic              mem_stall_i,
  input  logic              flush_i,
  output logic              Stall_o,
  output logic              MUX_Control_select_o,
  output logic              PC_write_o,
  output logic              IF_ID_write_o,
  output logic              ID_EX_write_o,
  output logic [1:0]        stall_cause_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  ldu_cnt_o,
  output logic [CNT_W-1:0]  mem_cnt_o
`endif
);

  logic   hit;
  cause_e cause;

  hazard_scoreboard #(
    .ADDR_W   (ADDR_W),
    .LOAD_LAT (LOAD_LAT)
  ) u_scoreboard (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rs1_addr    (IF_ID_RS1addr_i),
    .rs2_addr    (IF_ID_RS2addr_i),
    .rs1_use     (IF_ID_RS1use_i),
    .rs2_use     (IF_ID_RS2use_i),
    .ex_rd_addr  (ID_EX_RDaddr_i),
    .ex_mem_read (ID_EX_MemRead_i),
    .hold        (mem_stall_i),
    .hit         (hit)
  );

  // Priority arbitration: cache stall freezes everything, a flush overrides
  // a load-use stall (the dependent instruction is being discarded anyway)
  always_comb begin
    cause                = CAUSE_NONE;
    Stall_o              = 1'b0;
    MUX_Control_select_o = 1'b0;
    PC_write_o           = 1'b1;
    IF_ID_write_o        = 1'b1;
    ID_EX_write_o        = 1'b1;
    if (!rst_i) begin
      cause = CAUSE_NONE;
    end else if (mem_stall_i) begin
      cause         = CAUSE_MEM;
      PC_write_o    = 1'b0;
      IF_ID_write_o = 1'b0;
      ID_EX_write_o = 1'b0;
    end else if (flush_i) begin
      cause = CAUSE_FLUSH;
    end else if (hit) begin
      cause                = CAUSE_LDU;
      Stall_o              = 1'b1;
      MUX_Control_select_o = 1'b1;
      PC_write_o           = 1'b0;
      IF_ID_write_o        = 1'b0;
    end
  end

  assign stall_cause_o = cause;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] ldu_cnt;
  logic [CNT_W-1:0] mem_cnt;

  // Saturating per-cause cycle counters
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ldu_cnt <= '0;
      mem_cnt <= '0;
    end else begin
      if ((cause == CAUSE_LDU) && (ldu_cnt != '1)) ldu_cnt <= ldu_cnt + CNT_W'(1);
      if ((cause == CAUSE_MEM) && (mem_cnt != '1)) mem_cnt <= mem_cnt + CNT_W'(1);
    end
  end

  assign ldu_cnt_o = ldu_cnt;
  assign mem_cnt_o = mem_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Parametrised pipeline stall controller for the 5-stage core, replacing the single-cycle load-use detector in the ID stage. It tracks in-flight loads across a configurable number of post-EX stages in a small scoreboard and detects RS1/RS2 read-after-load hazards with x0 excluded. It arbitrates load-use stalls against data-cache stalls and branch flushes, and drives PC, IF/ID and ID/EX write enables plus the control-bubble mux.

## Interface
- ADDR_W, 5, register address width
- LOAD_LAT, 2, cycles after EX before load data is forwardable (1 = classic single bubble; legal 1..4)
- CNT_W, 32, perf counter width (only with macro)

- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, synchronous, active-low
- IF_ID_RS1addr_i / IF_ID_RS2addr_i  in  ADDR_W  source registers of instruction in ID
- IF_ID_RS1use_i / IF_ID_RS2use_i  in  1  instruction actually reads RS1/RS2
- ID_EX_RDaddr_i  in  ADDR_W  destination of instruction in EX
- ID_EX_MemRead_i  in  1  instruction in EX is a load
- mem_stall_i  in  1  data cache busy; whole pipeline must freeze
- flush_i  in  1  branch taken in ID; IF/ID being flushed
- Stall_o  out  1  load-use stall active
- MUX_Control_select_o  out  1  1 = inject bubble into ID/EX control
- PC_write_o / IF_ID_write_o / ID_EX_write_o  out  1  1 = register updates
- stall_cause_o  out  2  0 none, 1 load-use, 2 mem, 3 flush
- ldu_cnt_o / mem_cnt_o  out  CNT_W  perf counters (macro only)

## Operation
- Scoreboard: LOAD_LAT-1 registered stages SB[1..LOAD_LAT-1], each {v, rd}. Stage 0 is combinational: v = ID_EX_MemRead_i && ID_EX_RDaddr_i != 0.
- When mem_stall_i=0, on each clock: SB[1] <= stage 0; SB[k] <= SB[k-1]. When mem_stall_i=1, all SB stages hold.
- hit = any valid stage s with rd == RS1 && RS1use, or rd == RS2 && RS2use. Any rd == 0 never hits.
- Priority: mem_stall_i > flush_i > hit.
  - mem: all writes 0, MUX select 0, Stall_o 0, cause 2.
  - flush: all writes 1, MUX select 0, Stall_o 0, cause 3.
  - hit: PC/IF_ID write 0, ID_EX write 1, MUX select 1, Stall_o 1, cause 1.
  - none: all writes 1, select 0, cause 0.
- Flush does not clear the scoreboard; loads past EX are committed.
- LOAD_LAT=1: scoreboard has zero stages; behaviour equals classic single-bubble detection except for x0 and use-bit qualification.

## Timing
- All outputs are combinational from inputs and SB; no output register; zero-cycle latency.
- Load in EX with dependent instruction in ID stalls for exactly LOAD_LAT cycles, absent mem stalls. Each mem-stall cycle extends this by one, because SB holds.
- Reset (rst_i=0 at posedge): all SB v cleared, counters cleared. While rst_i=0, outputs forced to the "none" values (writes 1, select 0, cause 0), whatever the other inputs are.
- Reset asserted mid-stall aborts the stall at the next edge; pending loads are forgotten.
- Simultaneous mem_stall_i and hit: mem wins. The hit reappears once mem_stall_i drops, since SB is unchanged.

## Configuration
- HAZARD_PERF_CNT_EN defined: ldu_cnt_o increments on each cycle with cause 1, and mem_cnt_o on each cycle with cause 2. Both saturate at all-ones and are cleared by reset.
- Undefined: counters and ports absent, with zero counter flops.

## Structure
- Shared package hazard_pkg: cause encodings (CAUSE_NONE/LDU/MEM/FLUSH), REG_ZERO, and default ADDR_W.
- Sub-module hazard_scoreboard: SB shift register with hold, plus the stage-0 and registered-stage match logic. It outputs hit. The top holds only arbitration and counters.

## Test plan
- LOAD_LAT=1: load x5 in EX, ID reads x5 on RS1 -> Stall_o=1, PC_write=0, select=1 for 1 cycle, then cause 0.
- LOAD_LAT=2: load x7, dependent ID on RS2 -> Stall_o=1 for 2 consecutive cycles; ID_EX_write stays 1 throughout.
- Load to x0 with ID reading x0 -> no stall. RS2use=0 with RS2 == rd -> no stall.
- LOAD_LAT=3, load x9 dependent, mem_stall_i=1 for 4 cycles in the middle -> cause 2 with all writes 0 for 4 cycles; total load-use cycles still 3.
- hit and flush_i together -> Stall_o=0, all writes 1, cause 3. SB still flags x9 next cycle if a new ID reads it.
- Reset asserted during a 2-cycle stall -> next cycle no stall, SB empty. With HAZARD_PERF_CNT_EN and CNT_W=2, 5 load-use cycles -> ldu_cnt_o=3.
